// File: rtl/operand_skew_feeder_if.sv
// Command/result bundle between a host sequencer and the operand skew feeder.
// The master side loads buffers and starts runs; the slave side streams operands.
interface operand_skew_feeder_if #(
   parameter int ROW_NUMBER    = 4,
   parameter int COLUMN_NUMBER = 4,
   parameter int DATA_WIDTH    = 8
);
   logic                                     wr_en;
   logic                                     wr_sel;
   logic [7:0]                               wr_row;
   logic [7:0]                               wr_col;
   logic [DATA_WIDTH-1:0]                    wr_data;
   logic                                     start;
   logic [7:0]                               size_row_A;
   logic [7:0]                               size_column_B;
   logic [7:0]                               size_columnrow_AB;
   logic [ROW_NUMBER-1:0][DATA_WIDTH-1:0]    left_out;
   logic [COLUMN_NUMBER-1:0][DATA_WIDTH-1:0] top_out;
   logic                                     array_clear;
   logic                                     feed_valid;
   logic                                     busy;
   logic                                     done;
   logic                                     size_err;

   modport master (
      output wr_en, wr_sel, wr_row, wr_col, wr_data,
      output start, size_row_A, size_column_B, size_columnrow_AB,
      input  left_out, top_out, array_clear, feed_valid, busy, done, size_err
   );

   modport slave (
      input  wr_en, wr_sel, wr_row, wr_col, wr_data,
      input  start, size_row_A, size_column_B, size_columnrow_AB,
      output left_out, top_out, array_clear, feed_valid, busy, done, size_err
   );
endinterface

// File: rtl/operand_skew_feeder.sv
// Buffers A (MxK) and B (KxN) and replays them as diagonally skewed wavefronts
// into a systolic array: clear pulse, skewed feed, zero flush, done pulse.
module operand_skew_feeder #(
   parameter int ROW_NUMBER    = 4,
   parameter int COLUMN_NUMBER = 4,
   parameter int K_MAX         = 4,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   operand_skew_feeder_if.slave  bus
);
   localparam int RW = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
   localparam int CW = (COLUMN_NUMBER > 1) ? $clog2(COLUMN_NUMBER) : 1;
   localparam int KW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam logic [7:0] ROW_LIM    = 8'(ROW_NUMBER);
   localparam logic [7:0] COL_LIM    = 8'(COLUMN_NUMBER);
   localparam logic [7:0] K_LIM      = 8'(K_MAX);
   localparam logic [7:0] FLUSH_LAST = 8'(ROW_NUMBER + COLUMN_NUMBER - 2);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

   state_t                                   state_reg;
   logic [DATA_WIDTH-1:0]                    a_buf [ROW_NUMBER][K_MAX];
   logic [DATA_WIDTH-1:0]                    b_buf [K_MAX][COLUMN_NUMBER];
   logic [7:0]                               m_reg;
   logic [7:0]                               n_reg;
   logic [7:0]                               k_reg;
   logic [7:0]                               last_reg;
   logic [7:0]                               step_reg;
   logic [ROW_NUMBER-1:0][DATA_WIDTH-1:0]    left_reg;
   logic [ROW_NUMBER-1:0][DATA_WIDTH-1:0]    left_next;
   logic [COLUMN_NUMBER-1:0][DATA_WIDTH-1:0] top_reg;
   logic [COLUMN_NUMBER-1:0][DATA_WIDTH-1:0] top_next;
   logic                                     clear_reg;
   logic                                     valid_reg;
   logic                                     busy_reg;
   logic                                     done_reg;
   logic                                     err_reg;
   logic                                     err_pending_reg;
   logic [7:0]                               span;
   logic                                     sizes_ok;

   assign span = (bus.size_row_A > bus.size_column_B) ? bus.size_row_A : bus.size_column_B;
   assign sizes_ok = (bus.size_row_A != 8'd0) && (bus.size_row_A <= ROW_LIM) &&
                     (bus.size_column_B != 8'd0) && (bus.size_column_B <= COL_LIM) &&
                     (bus.size_columnrow_AB != 8'd0) && (bus.size_columnrow_AB <= K_LIM);

   // Out-of-range addresses are rejected before truncation so they cannot alias.
   always_ff @(posedge clk) begin
      if (bus.wr_en && !busy_reg) begin
         if (!bus.wr_sel && (bus.wr_row < ROW_LIM) && (bus.wr_col < K_LIM))
            a_buf[bus.wr_row[RW-1:0]][bus.wr_col[KW-1:0]] <= bus.wr_data;
         if (bus.wr_sel && (bus.wr_row < K_LIM) && (bus.wr_col < COL_LIM))
            b_buf[bus.wr_row[KW-1:0]][bus.wr_col[CW-1:0]] <= bus.wr_data;
      end
   end

   // Lane offset step-lane is taken one bit wider; bit 8 marks a negative offset.
   genvar gi;
   generate
      for (gi = 0; gi < ROW_NUMBER; gi++) begin : g_row
         logic [8:0] offs;
         assign offs = {1'b0, step_reg} - 9'(gi);
         assign left_next[gi] = ((8'(gi) < m_reg) && !offs[8] && (offs[7:0] < k_reg)) ?
                                a_buf[gi][offs[KW-1:0]] : '0;
      end
      for (gi = 0; gi < COLUMN_NUMBER; gi++) begin : g_col
         logic [8:0] offs;
         assign offs = {1'b0, step_reg} - 9'(gi);
         assign top_next[gi] = ((8'(gi) < n_reg) && !offs[8] && (offs[7:0] < k_reg)) ?
                               b_buf[offs[KW-1:0]][gi] : '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         left_reg        <= '0;
         top_reg         <= '0;
         clear_reg       <= 1'b0;
         valid_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         err_pending_reg <= 1'b0;
         step_reg        <= '0;
      end else begin
         clear_reg       <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= err_pending_reg;
         err_pending_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  if (sizes_ok) begin
                     m_reg     <= bus.size_row_A;
                     n_reg     <= bus.size_column_B;
                     k_reg     <= bus.size_columnrow_AB;
                     last_reg  <= bus.size_columnrow_AB + span - 8'd2;
                     state_reg <= CLEAR;
                  end else begin
                     err_pending_reg <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               clear_reg <= 1'b1;
               busy_reg  <= 1'b1;
               step_reg  <= '0;
               state_reg <= FEED;
            end
            FEED: begin
               left_reg  <= left_next;
               top_reg   <= top_next;
               valid_reg <= 1'b1;
               if (step_reg == last_reg) begin
                  step_reg  <= '0;
                  state_reg <= FLUSH;
               end else begin
                  step_reg <= step_reg + 8'd1;
               end
            end
            FLUSH: begin
               left_reg  <= '0;
               top_reg   <= '0;
               valid_reg <= 1'b0;
               if (step_reg == FLUSH_LAST) state_reg <= DONE;
               else step_reg <= step_reg + 8'd1;
            end
            DONE: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.left_out    = left_reg;
   assign bus.top_out     = top_reg;
   assign bus.array_clear = clear_reg;
   assign bus.feed_valid  = valid_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.size_err    = err_reg;
endmodule
